// File: rtl/alu_mext_pkg.sv
// Shared opcode, funct and FSM definitions for the RV32IM
// execute unit (base ALU, multiply and iterative divide).
package alu_mext_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    WB
  } exec_state_e;

  function automatic logic is_muldiv(
    input logic [6:0] opc,
    input logic [6:0] f7
  );
    return (opc == OPC_OP) && (f7 == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/alu_mext_alu.sv
// Combinational base-ISA ALU: arithmetic, address, branch,
// link and upper-immediate results.
// Ports: pc_i, a_i, b_i (b already muxed with immediate),
// opcode_i/funct3_i/funct7_i in; res_o, brtaken_o out.
// Branches compare a_i with b_i and form target pc_i + b_i.
module alu
  import alu_mext_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  output logic [DWIDTH-1:0] res_o,
  output logic              brtaken_o
);

  localparam int SW = $clog2(DWIDTH);

  logic [DWIDTH-1:0]        pcx;
  logic [DWIDTH-1:0]        arith;
  logic signed [DWIDTH-1:0] sra;
  logic [SW-1:0]            sh;
  logic                     sub;
  logic                     lt;
  logic                     ltu;
  logic                     eq;
  logic                     take;
  logic                     unused_f7;

  assign pcx = DWIDTH'(pc_i);
  assign sh  = b_i[SW-1:0];
  assign sub = (opcode_i == OPC_OP) && funct7_i[5];
  assign lt  = $signed(a_i) < $signed(b_i);
  assign ltu = a_i < b_i;
  assign eq  = a_i == b_i;
  assign sra = $signed(a_i) >>> sh;

  assign unused_f7 = ^{funct7_i[6], funct7_i[4:0]};

  always_comb begin
    arith = '0;
    unique case (funct3_i)
      F3_ADD:  arith = sub ? a_i - b_i : a_i + b_i;
      F3_SLL:  arith = a_i << sh;
      F3_SLT:  arith = DWIDTH'(lt);
      F3_SLTU: arith = DWIDTH'(ltu);
      F3_XOR:  arith = a_i ^ b_i;
      F3_SR:   arith = funct7_i[5] ? sra : a_i >> sh;
      F3_OR:   arith = a_i | b_i;
      F3_AND:  arith = a_i & b_i;
    endcase
  end

  always_comb begin
    take = 1'b0;
    unique case (funct3_i)
      F3_BEQ:  take = eq;
      F3_BNE:  take = !eq;
      F3_BLT:  take = lt;
      F3_BGE:  take = !lt;
      F3_BLTU: take = ltu;
      F3_BGEU: take = !ltu;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    res_o     = '0;
    brtaken_o = 1'b0;
    unique case (1'b1)
      opcode_i == OPC_LUI:    res_o = b_i;
      opcode_i == OPC_AUIPC:  res_o = pcx + b_i;
      opcode_i == OPC_JAL,
      opcode_i == OPC_JALR: begin
        res_o     = pcx + DWIDTH'(4);
        brtaken_o = 1'b1;
      end
      opcode_i == OPC_BRANCH: begin
        res_o     = pcx + b_i;
        brtaken_o = take;
      end
      opcode_i == OPC_LOAD,
      opcode_i == OPC_STORE:  res_o = a_i + b_i;
      opcode_i == OPC_OP,
      opcode_i == OPC_OPIMM:  res_o = arith;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_mext_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes, one
// quotient bit per cycle over DWIDTH cycles.
// Ports: clk, clr_i (abort), start_i, dividend_i, divisor_i in;
// quo_o, rem_o, done_o (last step happens this cycle) out.
module div_iter #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              start_i,
  input  logic [DWIDTH-1:0] dividend_i,
  input  logic [DWIDTH-1:0] divisor_i,
  output logic [DWIDTH-1:0] quo_o,
  output logic [DWIDTH-1:0] rem_o,
  output logic              done_o
);

  localparam int CW = $clog2(DWIDTH);

  logic [DWIDTH-1:0] quo_q;
  logic [DWIDTH-1:0] rem_q;
  logic [DWIDTH-1:0] dvs_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic [DWIDTH:0]   shifted;
  logic [DWIDTH:0]   diff;
  logic              fits;

  // quo_q doubles as the dividend shift register: its top
  // bit feeds the partial remainder, the new bit enters low.
  assign shifted = {rem_q, quo_q[DWIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = !diff[DWIDTH];

  assign quo_o  = quo_q;
  assign rem_o  = rem_q;
  assign done_o = busy_q && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (clr_i) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      cnt_q  <= CW'(DWIDTH - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      quo_q <= {quo_q[DWIDTH-2:0], fits};
      rem_q <= fits ? diff[DWIDTH-1:0]
                    : shifted[DWIDTH-1:0];
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mext.sv
// RV32IM execute unit: single-cycle base ALU, 2-cycle multiply
// and iterative divide behind a one-entry output register.
// Ports: clk, reset, valid_i/ready_o + pc_i, rs1_i, rs2_i,
// opcode_i, funct3_i, funct7_i in; flush_i; valid_o/ready_i,
// res_o, brtaken_o out.
module alu_mext
  import alu_mext_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] res_o,
  output logic              brtaken_o
);

  localparam int PW = 2 * DWIDTH;
  localparam logic [DWIDTH-1:0] MINV =
    {1'b1, {(DWIDTH-1){1'b0}}};

  exec_state_e state_q, state_d;

  logic              valid_q, valid_d;
  logic [DWIDTH-1:0] res_q, res_d;
  logic              br_q, br_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic              hi_q, hi_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              drem_q, drem_d;

  logic [DWIDTH-1:0] alu_res;
  logic              alu_br;
  logic              is_m;
  logic              is_mul;
  logic              is_div;
  logic              out_free;
  logic              accept;
  logic              sa;
  logic              sb;
  logic              dsgn;
  logic              drem;
  logic [PW-1:0]     a_ext;
  logic [PW-1:0]     b_ext;
  logic [PW-1:0]     prod;
  logic              rs1_neg;
  logic              rs2_neg;
  logic [DWIDTH-1:0] mag1;
  logic [DWIDTH-1:0] mag2;
  logic              div0;
  logic              ovf;
  logic              fast;
  logic [DWIDTH-1:0] fast_res;
  logic              div_start;
  logic              div_clr;
  logic [DWIDTH-1:0] div_quo;
  logic [DWIDTH-1:0] div_rem;
  logic              div_done;
  logic [DWIDTH-1:0] fix_res;

  alu #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_alu (
    .pc_i     (pc_i),
    .a_i      (rs1_i),
    .b_i      (rs2_i),
    .opcode_i (opcode_i),
    .funct3_i (funct3_i),
    .funct7_i (funct7_i),
    .res_o    (alu_res),
    .brtaken_o(alu_br)
  );

  assign is_m   = is_muldiv(opcode_i, funct7_i);
  assign is_mul = is_m && !funct3_i[2];
  assign is_div = is_m && funct3_i[2];

  assign out_free = !valid_q || ready_i;
  assign ready_o  = (state_q == IDLE) && out_free && !flush_i;
  assign accept   = valid_i && ready_o;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (funct3_i)
      FUNCT3_MULH: begin
        sa = 1'b1;
        sb = 1'b1;
      end
      FUNCT3_MULHSU: sa = 1'b1;
      FUNCT3_MUL, FUNCT3_MULHU: ;
      default: ;
    endcase
  end

  always_comb begin
    dsgn = 1'b0;
    drem = 1'b0;
    case (funct3_i)
      FUNCT3_DIV:  dsgn = 1'b1;
      FUNCT3_DIVU: ;
      FUNCT3_REM: begin
        dsgn = 1'b1;
        drem = 1'b1;
      end
      FUNCT3_REMU: drem = 1'b1;
      default: ;
    endcase
  end

  assign a_ext = {{DWIDTH{sa & rs1_i[DWIDTH-1]}}, rs1_i};
  assign b_ext = {{DWIDTH{sb & rs2_i[DWIDTH-1]}}, rs2_i};
  assign prod  = a_ext * b_ext;

  assign rs1_neg = dsgn && rs1_i[DWIDTH-1];
  assign rs2_neg = dsgn && rs2_i[DWIDTH-1];
  // The most negative value maps onto its own bit pattern,
  // which is exactly its unsigned magnitude.
  assign mag1 = rs1_neg ? -rs1_i : rs1_i;
  assign mag2 = rs2_neg ? -rs2_i : rs2_i;

  assign div0 = rs2_i == '0;
  assign ovf  = dsgn && (rs1_i == MINV) && (rs2_i == '1);
  assign fast = div0 || ovf;

  always_comb begin
    fast_res = '0;
    unique case (1'b1)
      div0 && drem:  fast_res = rs1_i;
      div0 && !drem: fast_res = '1;
      !div0 && drem: fast_res = '0;
      default:       fast_res = rs1_i;
    endcase
  end

  assign div_start = accept && is_div && !fast;
  assign div_clr   = reset || flush_i;

  div_iter #(
    .DWIDTH(DWIDTH)
  ) u_div (
    .clk       (clk),
    .clr_i     (div_clr),
    .start_i   (div_start),
    .dividend_i(mag1),
    .divisor_i (mag2),
    .quo_o     (div_quo),
    .rem_o     (div_rem),
    .done_o    (div_done)
  );

  assign fix_res = drem_q ? (rneg_q ? -div_rem : div_rem)
                          : (qneg_q ? -div_quo : div_quo);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q && !ready_i;
    res_d   = res_q;
    br_d    = br_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    drem_d  = drem_q;
    if (flush_i) begin
      valid_d = 1'b0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              prod_d  = prod;
              hi_d    = funct3_i != FUNCT3_MUL;
              state_d = MUL;
            end else if (is_div && !fast) begin
              qneg_d  = rs1_neg ^ rs2_neg;
              rneg_d  = rs1_neg;
              drem_d  = drem;
              state_d = DIV;
            end else begin
              valid_d = 1'b1;
              res_d   = is_div ? fast_res : alu_res;
              br_d    = !is_m && alu_br;
            end
          end
        end
        MUL: begin
          if (out_free) begin
            valid_d = 1'b1;
            res_d   = hi_q ? prod_q[PW-1:DWIDTH]
                           : prod_q[DWIDTH-1:0];
            br_d    = 1'b0;
            state_d = IDLE;
          end
        end
        DIV: begin
          if (div_done) begin
            state_d = WB;
          end
        end
        WB: begin
          if (out_free) begin
            valid_d = 1'b1;
            res_d   = fix_res;
            br_d    = 1'b0;
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      res_q   <= '0;
      br_q    <= 1'b0;
      prod_q  <= '0;
      hi_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      drem_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      br_q    <= br_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      drem_q  <= drem_d;
    end
  end

  assign valid_o   = valid_q;
  assign res_o     = res_q;
  assign brtaken_o = br_q;

endmodule
